// File: rtl/load_pkg.sv
// Shared constants for the load memory stage: funct3 encodings, FSM states and
// rd_error codes, plus small decode helpers.
package load_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef logic [1:0] load_err_t;

  localparam load_err_t ERR_NONE       = 2'd0;
  localparam load_err_t ERR_MISALIGNED = 2'd1;
  localparam load_err_t ERR_ILLEGAL    = 2'd2;
  localparam load_err_t ERR_TIMEOUT    = 2'd3;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] offset);
    logic w_mis;
    w_mis = 1'b0;
    if ((f3 == F3_LH) || (f3 == F3_LHU)) w_mis = offset[0];
    else if (f3 == F3_LW)                w_mis = (offset != 2'b00);
    return w_mis;
  endfunction

endpackage

// File: rtl/load_lane_extract.sv
// Selects the addressed byte/halfword lane of a little-endian word and
// sign- or zero-extends it according to funct3.
module load_lane_extract
  import load_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_word,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    unique case (i_offset)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

    case (i_funct3)
      F3_LB:   o_value = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_value = {{16{w_half[15]}}, w_half};
      F3_LW:   o_value = i_word;
      F3_LBU:  o_value = {24'd0, w_byte};
      F3_LHU:  o_value = {16'd0, w_half};
      default: o_value = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_memory_interface.sv
// Load-side memory stage: accepts one load, issues a word read, waits for a
// variable-latency response (with timeout) and returns the extended result.
module load_memory_interface
  import load_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_address,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        rd_valid,
  output logic [31:0] rd_value,
  output logic [1:0]  rd_error,
  output logic        busy
);

  localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state,    w_state_d;
  logic [2:0]  r_funct3,   w_funct3_d;
  logic [31:0] r_addr,     w_addr_d;
  logic [15:0] r_count,    w_count_d;
  logic [31:0] r_rd_value, w_rd_value_d;
  load_err_t   r_rd_error, w_rd_error_d;
  logic [31:0] w_extract;

  load_lane_extract u_extract (
    .i_funct3 (r_funct3),
    .i_offset (r_addr[1:0]),
    .i_word   (mem_resp_data),
    .o_value  (w_extract)
  );

  always_comb begin
    w_state_d    = r_state;
    w_funct3_d   = r_funct3;
    w_addr_d     = r_addr;
    w_count_d    = r_count;
    w_rd_value_d = r_rd_value;
    w_rd_error_d = r_rd_error;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_funct3_d = req_funct3;
          w_addr_d   = req_address;
          // Illegal funct3 outranks misalignment; neither reaches memory.
          if (!f3_legal(req_funct3)) begin
            w_state_d    = ST_RESP;
            w_rd_value_d = 32'd0;
            w_rd_error_d = ERR_ILLEGAL;
          end else if (f3_misaligned(req_funct3, req_address[1:0])) begin
            w_state_d    = ST_RESP;
            w_rd_value_d = 32'd0;
            w_rd_error_d = ERR_MISALIGNED;
          end else begin
            w_state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (mem_req_ready) begin
          w_state_d = ST_WAIT;
          w_count_d = 16'd0;
        end
      end
      ST_WAIT: begin
        // A response in the final WAIT cycle still beats the timeout.
        if (mem_resp_valid) begin
          w_state_d    = ST_RESP;
          w_rd_value_d = w_extract;
          w_rd_error_d = ERR_NONE;
        end else if (r_count == LP_LAST) begin
          w_state_d    = ST_RESP;
          w_rd_value_d = 32'd0;
          w_rd_error_d = ERR_TIMEOUT;
        end else begin
          w_count_d = r_count + 16'd1;
        end
      end
      ST_RESP: w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_funct3   <= 3'd0;
      r_addr     <= 32'd0;
      r_count    <= 16'd0;
      r_rd_value <= 32'd0;
      r_rd_error <= ERR_NONE;
    end else begin
      r_state    <= w_state_d;
      r_funct3   <= w_funct3_d;
      r_addr     <= w_addr_d;
      r_count    <= w_count_d;
      r_rd_value <= w_rd_value_d;
      r_rd_error <= w_rd_error_d;
    end
  end

  assign req_ready       = (r_state == ST_IDLE);
  assign busy            = (r_state != ST_IDLE);
  assign mem_req_valid   = (r_state == ST_ISSUE);
  assign mem_req_address = {r_addr[31:2], 2'b00};
  assign rd_valid        = (r_state == ST_RESP);
  assign rd_value        = r_rd_value;
  assign rd_error        = r_rd_error;

endmodule

// File: tb/tb_load_memory_interface.sv
// Self-checking bench for load_memory_interface: directed cases followed by
// randomized loads checked against an arithmetic reference model.
module tb_load_memory_interface;

  localparam int T = 8;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_address;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        rd_valid;
  logic [31:0] rd_value;
  logic [1:0]  rd_error;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  load_memory_interface #(.TIMEOUT_CYCLES(T)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_funct3      (req_funct3),
    .req_address     (req_address),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_address (mem_req_address),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data),
    .rd_valid        (rd_valid),
    .rd_value        (rd_value),
    .rd_error        (rd_error),
    .busy            (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: size/sign from funct3, alignment by modulo, lane by shifting.
  task automatic ref_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word,
                          output logic [31:0] val, output logic [1:0] err);
    int     size;
    bit     sgn;
    longint v;
    size = 0;
    sgn  = 0;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: size = 0;
    endcase
    val = 32'd0;
    if (size == 0) err = 2'd2;
    else if ((addr % size) != 0) err = 2'd1;
    else begin
      err = 2'd0;
      v = longint'(word >> (8 * (addr % 4)));
      if (size == 1) begin
        v = v % 256;
        if (sgn && v >= 128) v = v - 256;
      end else if (size == 2) begin
        v = v % 65536;
        if (sgn && v >= 32768) v = v - 65536;
      end
      val = 32'(v);
    end
  endtask

  // Starts at a negedge in IDLE; ends at the negedge of the first IDLE cycle after RESP.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word,
                         input int rdly, input int wdly, input bit late);
    logic [31:0] exp_val;
    logic [1:0]  exp_err;
    int          nwait;
    ref_load(f3, addr, word, exp_val, exp_err);
    check_eq("idle_req_ready", 32'(req_ready), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);
    req_valid   = 1'b1;
    req_funct3  = f3;
    req_address = addr;
    @(negedge clock);
    req_valid   = 1'b0;
    req_funct3  = 3'($urandom);
    req_address = $urandom;
    if (exp_err == 2'd0) begin
      check_eq("issue_req_ready", 32'(req_ready), 32'd0);
      for (int i = 0; i <= rdly; i++) begin
        check_eq("issue_mreq_valid", 32'(mem_req_valid), 32'd1);
        check_eq("issue_mreq_addr", mem_req_address, {addr[31:2], 2'b00});
        check_eq("issue_busy", 32'(busy), 32'd1);
        mem_req_ready  = (i == rdly);
        mem_resp_valid = 1'($urandom_range(0, 1));
        mem_resp_data  = $urandom;
        @(negedge clock);
      end
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (wdly + 1 > T) begin
        exp_val = 32'd0;
        exp_err = 2'd3;
      end
      nwait = (wdly + 1 > T) ? T : wdly + 1;
      for (int k = 1; k <= nwait; k++) begin
        check_eq("wait_mreq_valid", 32'(mem_req_valid), 32'd0);
        check_eq("wait_rd_valid", 32'(rd_valid), 32'd0);
        mem_resp_valid = (k == wdly + 1);
        mem_resp_data  = (k == wdly + 1) ? word : $urandom;
        @(negedge clock);
      end
      mem_resp_valid = 1'b0;
    end
    check_eq("resp_rd_valid", 32'(rd_valid), 32'd1);
    check_eq("resp_rd_value", rd_value, exp_val);
    check_eq("resp_rd_error", 32'(rd_error), 32'(exp_err));
    check_eq("resp_mreq_valid", 32'(mem_req_valid), 32'd0);
    if (late) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = $urandom;
    end
    @(negedge clock);
    check_eq("post_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("hold_rd_value", rd_value, exp_val);
    check_eq("hold_rd_error", 32'(rd_error), 32'(exp_err));
    if (late) begin
      mem_resp_data = $urandom;
      @(negedge clock);
      mem_resp_valid = 1'b0;
      check_eq("late_rd_valid", 32'(rd_valid), 32'd0);
      check_eq("late_busy", 32'(busy), 32'd0);
    end
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    req_valid      = 1'b0;
    req_funct3     = 3'd0;
    req_address    = 32'd0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'd0;
    @(negedge clock);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_mreq_valid", 32'(mem_req_valid), 32'd0);
    check_eq("rst_rd_value", rd_value, 32'd0);
    check_eq("rst_mreq_addr", mem_req_address, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    do_load(3'd0, 32'h0000_1003, 32'h8012_3456, 0, 0, 1'b0);
    do_load(3'd4, 32'h0000_2002, 32'h89AB_CDEF, 0, 1, 1'b0);
    do_load(3'd5, 32'h0000_2002, 32'h89AB_CDEF, 1, 0, 1'b0);
    do_load(3'd1, 32'h0000_2002, 32'h89AB_CDEF, 0, 2, 1'b0);
    do_load(3'd2, 32'h0000_3001, 32'h1234_5678, 0, 0, 1'b0);
    do_load(3'd3, 32'h0000_3000, 32'h1234_5678, 0, 0, 1'b0);
    do_load(3'd2, 32'h0000_4000, 32'hDEAD_BEEF, 4, 6, 1'b0);
    do_load(3'd2, 32'h0000_5004, 32'hCAFE_F00D, 0, 20, 1'b1);
    do_load(3'd2, 32'h0000_5008, 32'h0BAD_CAFE, 0, 0, 1'b0);
    do_load(3'd5, 32'h0000_6001, 32'h0BAD_CAFE, 0, 0, 1'b0);
    do_load(3'd6, 32'h0000_6001, 32'h0BAD_CAFE, 0, 0, 1'b0);

    // Reset while waiting for a response.
    req_valid   = 1'b1;
    req_funct3  = 3'd2;
    req_address = 32'h0000_7000;
    @(negedge clock);
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    @(negedge clock);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("mid_rst_mreq_valid", 32'(mem_req_valid), 32'd0);
    @(negedge clock);
    reset_n        = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1111_2222;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    check_eq("post_rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    @(negedge clock);
    check_eq("post_rst_rd_valid2", 32'(rd_valid), 32'd0);
    do_load(3'd0, 32'h0000_7001, 32'h0000_7F00, 0, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      do_load(3'($urandom_range(0, 7)), $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 10), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
